dcache_assoc_sram: RTL
======================

# dcache_assoc_sram

Parametrised N-way set-associative data-cache storage array with true-LRU replacement, per-line valid/dirty state and an optional write-back flush engine. Sits between the dcache controller and the line storage. Serves combinational tag lookups and performs clocked line writes, refills and LRU updates. When flush is compiled in, it streams every dirty line to the memory-side write-back port under a valid/ready handshake.

## Interface
- WAYS, 4, associativity; power of two, 2..8
- SETS, 16, number of sets; power of two
- TAG_W, 23, address tag bits
- LINE_W, 256, line width in bits
- SET_W, $clog2(SETS), derived; do not override
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset; synchronous, active-high
- addr_i  in  SET_W  set index
- tag_i  in  TAG_W+2  {valid, dirty, tag}; valid bit ignored on write (forced 1)
- data_i  in  LINE_W  write/refill line
- enable_i  in  1  access strobe
- write_i  in  1  write when enable_i=1
- tag_o  out  TAG_W+2  {valid, dirty, tag} of hit way, else of victim way
- data_o  out  LINE_W  hit-way line, else victim line
- hit_o  out  1  lookup hit
- flush_i  in  1  start-flush pulse
- flush_busy_o  out  1  flush in progress
- flush_done_o  out  1  one-cycle completion pulse
- wb_valid_o  out  1  write-back request
- wb_ready_i  in  1  write-back accept
- wb_addr_o  out  TAG_W+SET_W  {tag, set} of line being written back
- wb_data_o  out  LINE_W  line being written back

## Operation
- Lookup (combinational): hit when some way of set addr_i has valid=1 and a matching tag. If several ways match (illegal), the lowest index wins.
- Victim: lowest-index invalid way; if all valid, the way with the maximum age.
- Write, enable_i=1 and write_i=1: on hit, overwrite that way. On miss, overwrite the victim. Stored tag is {1, tag_i dirty bit, tag_i tag}.
- LRU: per-set age array of $clog2(WAYS) bits per way, always a permutation of 0..WAYS-1.
  - Reset value of way w's age is w.
  - Touched way gets age 0. Ways younger than its old age increment by 1.
  - Touch occurs on a read hit or on any write. A read miss does not touch, so the victim is stable until refill.
- Flush FSM:
  - IDLE: on flush_i, go to SCAN with pointer (set 0, way 0).
  - SCAN: if the pointed line is valid and dirty, go to WB; otherwise advance the pointer (way first, then set).
  - WB: wb_valid_o=1 and wb_* are held stable until wb_ready_i. On handshake, clear the dirty bit, advance the pointer, return to SCAN.
  - When the pointer passes the last set/way, go to DONE.
  - DONE: pulse flush_done_o for one cycle, then IDLE.
- While flush_busy_o=1: enable_i is ignored (no writes, no LRU touch), hit_o is forced 0, and flush_i is ignored.
- Simultaneous flush_i and write while IDLE: the write commits; the flush scans post-write state.

## Timing
- Read path: addr_i/tag_i to hit_o/tag_o/data_o is combinational, zero latency.
- Writes, LRU and dirty clears become visible one cycle after the edge.
- Reset outputs: hit_o=0, tag_o valid=0, flush_busy_o=0, flush_done_o=0, wb_valid_o=0. All valid/dirty bits cleared; data contents are not reset.
- Flush duration: WAYS×SETS SCAN cycles, plus per dirty line 1 WB cycle and any ready stall, plus 1 DONE cycle.
- rst_i mid-flush: return to IDLE immediately with no done pulse. wb_valid_o drops in the same edge.

## Configuration
- DCACHE_FLUSH_EN defined: flush FSM and wb_* port logic are present.
- DCACHE_FLUSH_EN undefined: flush_i and wb_ready_i are ignored; flush_busy_o, flush_done_o and wb_valid_o are tied 0; wb_addr_o and wb_data_o are tied 0.
- Lookup, write and LRU behaviour are identical in both builds.

## Structure
- Package dcache_pkg:
  - default WAYS/SETS/TAG_W/LINE_W
  - flush state enum (IDLE, SCAN, WB, DONE)
  - tag-entry field offsets (VALID_BIT, DIRTY_BIT)
- Sub-module dcache_lru: per-set age storage, touch update and victim selection (invalid-first, then oldest). Parametrised by WAYS/SETS.

## Test plan
- Reset, then lookup set 3 tag 0x12 -> hit_o=0, tag_o valid=0; victim is way 0.
- Refill set 5 with tags 0xA,0xB,0xC,0xD (ways 0..3), then read 0xA, then refill 0xE -> 0xE replaces way 1 (0xB); a read of 0xB misses.
- Write hit to 0xA with data all-0xAA and dirty=1 -> next lookup returns hit_o=1, data all-0xAA, tag_o={1,1,0xA}; LRU shows way 0 age 0.
- Only ways 0,1 of set 7 valid; miss on set 7 -> tag_o valid=0, victim way 2 regardless of ages.
- DCACHE_FLUSH_EN, two dirty lines (set 2 way 1, set 9 way 3), wb_ready_i low for 3 cycles on the first:
  - wb_addr_o/wb_data_o are stable while stalled.
  - Both dirty bits are cleared afterward.
  - flush_done_o pulses after 64+2+3+1 cycles.
- Assert rst_i while in WB -> next cycle flush_busy_o=0 and wb_valid_o=0, no flush_done_o, all valid bits 0.

Source files
------------

// File: rtl/dcache_assoc_sram_pkg.sv
// Shared types and defaults for the set-associative dcache storage array.
// Field offsets are relative to the top of the tag field in a tag entry.
package dcache_pkg;

  localparam int DEF_WAYS   = 4;
  localparam int DEF_SETS   = 16;
  localparam int DEF_TAG_W  = 23;
  localparam int DEF_LINE_W = 256;

  // entry = {valid, dirty, tag}; bit index = TAG_W + offset
  localparam int VALID_BIT = 1;
  localparam int DIRTY_BIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WB,
    DONE
  } flush_state_e;

endpackage

// File: rtl/dcache_assoc_sram_lru.sv
// True-LRU age storage per set, with touch update and victim selection.
// Victim is the lowest invalid way, else the way holding the maximum age.
module dcache_lru #(
  parameter int WAYS = 4,
  parameter int SETS = 16,
  localparam int WAY_W = $clog2(WAYS),
  localparam int SET_W = $clog2(SETS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [SET_W-1:0] rd_set_i,
  input  logic [WAYS-1:0]  valid_i,
  input  logic             touch_i,
  input  logic [SET_W-1:0] touch_set_i,
  input  logic [WAY_W-1:0] touch_way_i,
  output logic [WAY_W-1:0] victim_o
);

  logic [WAY_W-1:0] age_q [SETS][WAYS];
  logic [WAY_W-1:0] old_age;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] old_way;
  logic             inv_found;

  assign old_age = age_q[touch_set_i][touch_way_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
    end else if (touch_i) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touch_way_i)
          age_q[touch_set_i][w] <= '0;
        else if (age_q[touch_set_i][w] < old_age)
          age_q[touch_set_i][w] <=
            age_q[touch_set_i][w] + WAY_W'(1);
      end
    end
  end

  always_comb begin
    inv_way   = '0;
    inv_found = 1'b0;
    old_way   = '0;
    // descending scan so the lowest index is the last assignment
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        inv_way   = WAY_W'(w);
        inv_found = 1'b1;
      end
      if (age_q[rd_set_i][w] == WAY_W'(WAYS - 1))
        old_way = WAY_W'(w);
    end
    victim_o = inv_found ? inv_way : old_way;
  end

endmodule

// File: rtl/dcache_assoc_sram.sv
// N-way set-associative dcache storage with true-LRU and valid/dirty state.
// Optional write-back flush engine enabled by DCACHE_FLUSH_EN.
module dcache_assoc_sram
  import dcache_pkg::*;
#(
  parameter int WAYS   = DEF_WAYS,
  parameter int SETS   = DEF_SETS,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int LINE_W = DEF_LINE_W,
  localparam int SET_W = $clog2(SETS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [SET_W-1:0]       addr_i,
  input  logic [TAG_W+1:0]       tag_i,
  input  logic [LINE_W-1:0]      data_i,
  input  logic                   enable_i,
  input  logic                   write_i,
  output logic [TAG_W+1:0]       tag_o,
  output logic [LINE_W-1:0]      data_o,
  output logic                   hit_o,
  input  logic                   flush_i,
  output logic                   flush_busy_o,
  output logic                   flush_done_o,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [TAG_W+SET_W-1:0] wb_addr_o,
  output logic [LINE_W-1:0]      wb_data_o
);

  localparam int WAY_W = $clog2(WAYS);
  localparam int PTR_W = SET_W + WAY_W;

  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];

  logic             hit_raw;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;
  logic [WAY_W-1:0] sel_way;
  logic             busy;
  logic             acc;
  logic             wr;
  logic             touch;
  logic             wb_clr;
  logic [SET_W-1:0] ptr_set;
  logic [WAY_W-1:0] ptr_way;
  logic             unused_ok;

  always_comb begin
    hit_raw = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[addr_i][w] &&
          tag_q[addr_i][w] == tag_i[TAG_W-1:0]) begin
        hit_raw = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  dcache_lru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_set_i    (addr_i),
    .valid_i     (valid_q[addr_i]),
    .touch_i     (touch),
    .touch_set_i (addr_i),
    .touch_way_i (sel_way),
    .victim_o    (victim)
  );

  assign sel_way = hit_raw ? hit_way : victim;
  assign tag_o   = {valid_q[addr_i][sel_way],
                    dirty_q[addr_i][sel_way],
                    tag_q[addr_i][sel_way]};
  assign data_o  = data_q[addr_i][sel_way];
  assign hit_o   = hit_raw & ~busy;

  assign acc   = enable_i & ~busy;
  assign wr    = acc & write_i;
  // read misses leave ages alone so the victim holds until refill
  assign touch = acc & (write_i | hit_raw);

  always_ff @(posedge clk_i) begin
    if (wr) begin
      tag_q[addr_i][sel_way]  <= tag_i[TAG_W-1:0];
      data_q[addr_i][sel_way] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      if (wr) begin
        valid_q[addr_i][sel_way] <= 1'b1;
        dirty_q[addr_i][sel_way] <= tag_i[TAG_W+DIRTY_BIT];
      end
      if (wb_clr)
        dirty_q[ptr_set][ptr_way] <= 1'b0;
    end
  end

`ifdef DCACHE_FLUSH_EN

  flush_state_e     state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             last;
  logic             line_dirty;

  assign ptr_set    = ptr_q[WAY_W +: SET_W];
  assign ptr_way    = ptr_q[WAY_W-1:0];
  assign last       = &ptr_q;
  assign line_dirty = valid_q[ptr_set][ptr_way] &
                      dirty_q[ptr_set][ptr_way];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wb_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = SCAN;
          ptr_d   = '0;
        end
      end
      SCAN: begin
        if (line_dirty) begin
          state_d = WB;
        end else begin
          ptr_d   = ptr_q + PTR_W'(1);
          state_d = last ? DONE : SCAN;
        end
      end
      WB: begin
        if (wb_ready_i) begin
          wb_clr  = 1'b1;
          ptr_d   = ptr_q + PTR_W'(1);
          state_d = last ? DONE : SCAN;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy         = state_q != IDLE;
  assign flush_busy_o = busy;
  assign flush_done_o = state_q == DONE;
  assign wb_valid_o   = state_q == WB;
  assign wb_addr_o    = {tag_q[ptr_set][ptr_way], ptr_set};
  assign wb_data_o    = data_q[ptr_set][ptr_way];
  assign unused_ok    = tag_i[TAG_W+VALID_BIT];

`else

  assign busy         = 1'b0;
  assign wb_clr       = 1'b0;
  assign ptr_set      = '0;
  assign ptr_way      = '0;
  assign flush_busy_o = 1'b0;
  assign flush_done_o = 1'b0;
  assign wb_valid_o   = 1'b0;
  assign wb_addr_o    = '0;
  assign wb_data_o    = '0;
  assign unused_ok    = ^{tag_i[TAG_W+VALID_BIT],
                          flush_i, wb_ready_i, PTR_W'(0)};

`endif

endmodule
